sm_register_rv: RTL



---
 rtl/sm_pkg.sv | 26 ++
 rtl/sm_register_we.sv | 28 ++
 rtl/sm_register_rv.sv | 128 ++++++++++++
 3 files changed

// File: rtl/sm_pkg.sv
// Shared definitions for the sm_register family: valid/ready stage state
// encoding and the width of the occupancy count.
package sm_pkg;

    // State is built from the two valid flops: bit 0 = main valid, bit 1 = skid valid.
    typedef enum logic [1:0] {
        SM_RV_EMPTY = 2'b00,
        SM_RV_ONE   = 2'b01,
        SM_RV_FULL  = 2'b11
    } sm_rv_state_e;

    localparam int SM_COUNT_W = 2;

    // Number of stored words for a given state.
    function automatic logic [SM_COUNT_W-1:0] sm_rv_count(input sm_rv_state_e st);
        logic [SM_COUNT_W-1:0] n;
        case (st)
            SM_RV_EMPTY: n = 2'd0;
            SM_RV_ONE:   n = 2'd1;
            SM_RV_FULL:  n = 2'd2;
            default:     n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/sm_register_we.sv
// Plain register with load enable and asynchronous active-low reset.
// Holds its value when we is low.
module sm_register_we #(
    parameter int SIZE = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [SIZE-1:0] d,
    output logic [SIZE-1:0] q
);

    logic [SIZE-1:0] data_q;

    // Load d on enable, otherwise keep the stored word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
        end else if (we) begin
            data_q <= d;
        end else begin
            data_q <= data_q;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/sm_register_rv.sv
// Two-entry (main + skid) pipeline register with valid/ready on both sides.
// in_ready, out_valid, out_data and count all come straight from flops, so
// there is no combinational path from out_ready to in_ready.
module sm_register_rv
    import sm_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SIZE-1:0]       in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SIZE-1:0]       out_data,
    output logic [SM_COUNT_W-1:0] count
);

    sm_rv_state_e          state_q, state_d;
    logic                  in_ready_q, in_ready_d;
    logic [SM_COUNT_W-1:0] count_q, count_d;
    logic                  main_we_s, skid_we_s, main_sel_skid_s;
    logic [SIZE-1:0]       main_d, main_q, skid_q;
    logic                  in_xfer_s, out_xfer_s;

    assign out_valid  = state_q[0];
    assign in_xfer_s  = in_valid & in_ready_q;
    assign out_xfer_s = state_q[0] & out_ready;

    // State, ready flag and count registers; in_ready stays low during reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= SM_RV_EMPTY;
            in_ready_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            count_q    <= count_d;
        end
    end

    // Next state and storage load controls from the two transfer events.
    always_comb begin
        state_d         = state_q;
        main_we_s       = 1'b0;
        skid_we_s       = 1'b0;
        main_sel_skid_s = 1'b0;
        case (state_q)
            SM_RV_EMPTY: begin
                if (in_xfer_s) begin
                    state_d   = SM_RV_ONE;
                    main_we_s = 1'b1;
                end else begin
                    state_d   = SM_RV_EMPTY;
                end
            end
            SM_RV_ONE: begin
                case ({in_xfer_s, out_xfer_s})
                    2'b10: begin
                        state_d   = SM_RV_FULL;
                        skid_we_s = 1'b1;
                    end
                    2'b01: begin
                        state_d   = SM_RV_EMPTY;
                    end
                    2'b11: begin
                        state_d   = SM_RV_ONE;
                        main_we_s = 1'b1;
                    end
                    default: begin
                        state_d   = SM_RV_ONE;
                    end
                endcase
            end
            SM_RV_FULL: begin
                // in_ready is low here, so only the output side can move.
                if (out_xfer_s) begin
                    state_d         = SM_RV_ONE;
                    main_we_s       = 1'b1;
                    main_sel_skid_s = 1'b1;
                end else begin
                    state_d         = SM_RV_FULL;
                end
            end
            default: begin
                state_d = SM_RV_EMPTY;
            end
        endcase
    end

    // Registered flags derived from the next state.
    always_comb begin
        in_ready_d = (state_d != SM_RV_FULL);
        count_d    = sm_rv_count(state_d);
    end

    // Main is refilled from skid when draining FULL, else from the producer.
    always_comb begin
        if (main_sel_skid_s) begin
            main_d = skid_q;
        end else begin
            main_d = in_data;
        end
    end

    sm_register_we #(.SIZE(SIZE)) u_main (
        .clk (clk),
        .rst (rst),
        .we  (main_we_s),
        .d   (main_d),
        .q   (main_q)
    );

    sm_register_we #(.SIZE(SIZE)) u_skid (
        .clk (clk),
        .rst (rst),
        .we  (skid_we_s),
        .d   (in_data),
        .q   (skid_q)
    );

    assign in_ready = in_ready_q;
    assign out_data = main_q;
    assign count    = count_q;

endmodule
